// File: rtl/serial_bus_arbiter_if.sv
// Serial shared-bus signal bundle between the master ports, the arbiter and
// the bus interconnect. The "master" modport is the arbiter's view: it owns
// the grant and bus-phase strobes. The "slave" modport is the opposite side,
// i.e. the requesting masters and the addressed slave's acknowledge.
interface serial_bus_arbiter_if;
    logic [1:0] M_REQ;
    logic [1:0] M_DONE;
    logic       S_READY;
    logic [1:0] M_GRANT;
    logic       B_UTIL;
    logic       A_ADD;
    logic       B_ERR;

    modport master (
        input  M_REQ,
        input  M_DONE,
        input  S_READY,
        output M_GRANT,
        output B_UTIL,
        output A_ADD,
        output B_ERR
    );

    modport slave (
        output M_REQ,
        output M_DONE,
        output S_READY,
        input  M_GRANT,
        input  B_UTIL,
        input  A_ADD,
        input  B_ERR
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Two-master round-robin arbiter and transaction sequencer for the serial
// shared bus. Walks IDLE -> GRANT -> ADDR -> WAIT_ACK -> DATA -> RELEASE,
// drives the one-hot grant and the B_UTIL / A_ADD phase strobes, and bounds
// the wait for the slave acknowledge with a timeout that raises B_ERR.
module serial_bus_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int TIMEOUT    = 15
) (
    input logic                  CLK,
    input logic                  RST,
    serial_bus_arbiter_if.master bus
);

    localparam int CW = $clog2(ADDR_WIDTH + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] ADDR_ONE  = CW'(1);
    localparam logic [7:0]    TO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ADDR,
        WAIT_ACK,
        DATA,
        RELEASE
    } state_t;

    state_t        state, nxt_state;
    logic          g, nxt_g;
    logic          last, nxt_last;
    logic          err, nxt_err;
    logic [CW-1:0] addr_cnt, nxt_addr_cnt;
    logic [7:0]    to_cnt, nxt_to_cnt;

    logic          win;
    logic          req_g;
    logic          done_g;

    logic [1:0]    grant_d;
    logic          util_d;
    logic          add_d;
    logic          err_d;

    // Next-state, winner selection and counter control; outputs are decoded
    // from the next state so that every strobe leaves a flop (Moore, registered).
    always_comb begin
        nxt_state    = state;
        nxt_g        = g;
        nxt_last     = last;
        nxt_err      = err;
        nxt_addr_cnt = addr_cnt;
        nxt_to_cnt   = to_cnt;
        win          = 1'b0;
        req_g        = bus.M_REQ[g];
        done_g       = bus.M_DONE[g];
        grant_d      = '0;
        util_d       = 1'b0;
        add_d        = 1'b0;
        err_d        = 1'b0;

        case (state)
            IDLE: begin
                if (|bus.M_REQ) begin
                    // Both requesting: the master that did not win last time.
                    if (bus.M_REQ == 2'b11) win = ~last;
                    else                    win = bus.M_REQ[1];
                    nxt_g     = win;
                    nxt_last  = win;
                    nxt_state = GRANT;
                end
            end
            GRANT: begin
                if (!req_g) begin
                    nxt_state = RELEASE;
                end else begin
                    nxt_addr_cnt = '0;
                    nxt_state    = ADDR;
                end
            end
            ADDR: begin
                if (!req_g) begin
                    nxt_state = RELEASE;
                end else if (addr_cnt == ADDR_LAST) begin
                    nxt_to_cnt = '0;
                    nxt_state  = WAIT_ACK;
                end else begin
                    nxt_addr_cnt = addr_cnt + ADDR_ONE;
                end
            end
            WAIT_ACK: begin
                // Ready is tested before the timeout so it wins a tie.
                if (!req_g) begin
                    nxt_state = RELEASE;
                end else if (bus.S_READY) begin
                    nxt_state = DATA;
                end else if (to_cnt == TO_LAST) begin
                    nxt_err   = 1'b1;
                    nxt_state = RELEASE;
                end else begin
                    nxt_to_cnt = to_cnt + 8'd1;
                end
            end
            DATA: begin
                if (!req_g || done_g) nxt_state = RELEASE;
            end
            RELEASE: begin
                nxt_err   = 1'b0;
                nxt_state = IDLE;
            end
            default: begin
                nxt_err   = 1'b0;
                nxt_state = IDLE;
            end
        endcase

        case (nxt_state)
            GRANT: begin
                grant_d = nxt_g ? 2'b10 : 2'b01;
            end
            ADDR: begin
                grant_d = nxt_g ? 2'b10 : 2'b01;
                util_d  = 1'b1;
                add_d   = 1'b1;
            end
            WAIT_ACK, DATA: begin
                grant_d = nxt_g ? 2'b10 : 2'b01;
                util_d  = 1'b1;
            end
            RELEASE: begin
                err_d = nxt_err;
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    // State, round-robin pointer, counters and registered bus outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            g           <= 1'b0;
            last        <= 1'b1;
            err         <= 1'b0;
            addr_cnt    <= '0;
            to_cnt      <= '0;
            bus.M_GRANT <= '0;
            bus.B_UTIL  <= 1'b0;
            bus.A_ADD   <= 1'b0;
            bus.B_ERR   <= 1'b0;
        end else begin
            state       <= nxt_state;
            g           <= nxt_g;
            last        <= nxt_last;
            err         <= nxt_err;
            addr_cnt    <= nxt_addr_cnt;
            to_cnt      <= nxt_to_cnt;
            bus.M_GRANT <= grant_d;
            bus.B_UTIL  <= util_d;
            bus.A_ADD   <= add_d;
            bus.B_ERR   <= err_d;
        end
    end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter (ADDR_WIDTH=2, TIMEOUT=15). Each step
// drives the inputs, pushes the bus outputs expected after the next rising
// edge to a scoreboard queue, then pops and compares once the edge has passed.
// Output vector layout: {M_GRANT[1:0], B_UTIL, A_ADD, B_ERR}.
module tb_serial_bus_arbiter;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sb_t;

    localparam logic [4:0] O_OFF  = 5'b00_000;
    localparam logic [4:0] O_ERR  = 5'b00_001;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    sb_t  sb_q[$];

    serial_bus_arbiter_if bus_if ();

    serial_bus_arbiter #(
        .ADDR_WIDTH (2),
        .TIMEOUT    (15)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] ov(input logic [1:0] gnt, input logic u,
                                      input logic a, input logic e);
        return {gnt, u, a, e};
    endfunction

    task automatic push_exp(input string tag, input logic [4:0] exp);
        sb_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic pop_check();
        sb_t        it;
        logic [4:0] obs;
        it  = sb_q.pop_front();
        obs = {bus_if.M_GRANT, bus_if.B_UTIL, bus_if.A_ADD, bus_if.B_ERR};
        n_tests++;
        assert (obs === it.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", it.tag, obs, it.exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] req, input logic [1:0] done,
                        input logic rdy, input string tag, input logic [4:0] exp);
        bus_if.M_REQ   = req;
        bus_if.M_DONE  = done;
        bus_if.S_READY = rdy;
        push_exp(tag, exp);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    // One complete transfer with the slave already ready: GRANT, 2x ADDR,
    // WAIT_ACK, three DATA cycles, done -> RELEASE, IDLE.
    task automatic txn(input logic [1:0] req, input logic [1:0] gnt, input string tag);
        step(req, 2'b00, 1'b1, {tag, "_grant"}, ov(gnt, 1'b0, 1'b0, 1'b0));
        step(req, 2'b00, 1'b1, {tag, "_addr0"}, ov(gnt, 1'b1, 1'b1, 1'b0));
        step(req, 2'b00, 1'b1, {tag, "_addr1"}, ov(gnt, 1'b1, 1'b1, 1'b0));
        step(req, 2'b00, 1'b1, {tag, "_wait"},  ov(gnt, 1'b1, 1'b0, 1'b0));
        step(req, 2'b00, 1'b1, {tag, "_data0"}, ov(gnt, 1'b1, 1'b0, 1'b0));
        step(req, 2'b00, 1'b1, {tag, "_data1"}, ov(gnt, 1'b1, 1'b0, 1'b0));
        step(req, 2'b00, 1'b1, {tag, "_data2"}, ov(gnt, 1'b1, 1'b0, 1'b0));
        step(req, gnt,   1'b1, {tag, "_rel"},   O_OFF);
        step(req, 2'b00, 1'b1, {tag, "_idle"},  O_OFF);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        bus_if.M_REQ   = 2'b00;
        bus_if.M_DONE  = 2'b00;
        bus_if.S_READY = 1'b0;
        rst            = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        push_exp("reset_state", O_OFF);
        pop_check();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2'b00, 2'b00, 1'b0, "idle_no_req", O_OFF);

        // Contention: grants alternate starting with master 0
        txn(2'b11, 2'b01, "cont0");
        txn(2'b11, 2'b10, "cont1");
        txn(2'b11, 2'b01, "cont2");
        txn(2'b11, 2'b10, "cont3");

        // Single master, normal transfer
        txn(2'b01, 2'b01, "single");

        // Timeout: 15 WAIT_ACK cycles, M_DONE ignored while waiting, B_ERR pulse
        step(2'b01, 2'b00, 1'b0, "to_grant", ov(2'b01, 1'b0, 1'b0, 1'b0));
        step(2'b01, 2'b00, 1'b0, "to_addr0", ov(2'b01, 1'b1, 1'b1, 1'b0));
        step(2'b01, 2'b00, 1'b0, "to_addr1", ov(2'b01, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < 15; i++)
            step(2'b01, (i == 7) ? 2'b01 : 2'b00, 1'b0, "to_wait", ov(2'b01, 1'b1, 1'b0, 1'b0));
        step(2'b01, 2'b00, 1'b0, "to_rel_err", O_ERR);
        step(2'b00, 2'b00, 1'b0, "to_idle", O_OFF);
        step(2'b00, 2'b00, 1'b0, "to_idle2", O_OFF);

        // Same master is still granted after a timeout
        txn(2'b01, 2'b01, "after_to");

        // Boundary: S_READY on the 15th WAIT_ACK cycle wins over the timeout
        step(2'b01, 2'b00, 1'b0, "bd_grant", ov(2'b01, 1'b0, 1'b0, 1'b0));
        step(2'b01, 2'b00, 1'b0, "bd_addr0", ov(2'b01, 1'b1, 1'b1, 1'b0));
        step(2'b01, 2'b00, 1'b0, "bd_addr1", ov(2'b01, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < 15; i++)
            step(2'b01, 2'b00, 1'b0, "bd_wait", ov(2'b01, 1'b1, 1'b0, 1'b0));
        step(2'b01, 2'b00, 1'b1, "bd_ready_wins", ov(2'b01, 1'b1, 1'b0, 1'b0));
        step(2'b01, 2'b10, 1'b0, "bd_data_other_done", ov(2'b01, 1'b1, 1'b0, 1'b0));
        step(2'b01, 2'b00, 1'b0, "bd_data", ov(2'b01, 1'b1, 1'b0, 1'b0));
        step(2'b01, 2'b01, 1'b0, "bd_rel", O_OFF);
        step(2'b00, 2'b00, 1'b0, "bd_idle", O_OFF);

        // Abort: M_REQ[0] drops in the second ADDR cycle, pending master 1 follows
        step(2'b01, 2'b00, 1'b1, "ab_grant", ov(2'b01, 1'b0, 1'b0, 1'b0));
        step(2'b11, 2'b00, 1'b1, "ab_addr0", ov(2'b01, 1'b1, 1'b1, 1'b0));
        step(2'b11, 2'b00, 1'b1, "ab_addr1", ov(2'b01, 1'b1, 1'b1, 1'b0));
        step(2'b10, 2'b00, 1'b1, "ab_rel_noerr", O_OFF);
        step(2'b10, 2'b00, 1'b1, "ab_idle", O_OFF);
        step(2'b10, 2'b00, 1'b1, "ab_grant_m1", ov(2'b10, 1'b0, 1'b0, 1'b0));
        step(2'b10, 2'b00, 1'b1, "ab_m1_addr0", ov(2'b10, 1'b1, 1'b1, 1'b0));
        step(2'b10, 2'b00, 1'b1, "ab_m1_addr1", ov(2'b10, 1'b1, 1'b1, 1'b0));
        step(2'b10, 2'b00, 1'b1, "ab_m1_wait", ov(2'b10, 1'b1, 1'b0, 1'b0));
        step(2'b10, 2'b00, 1'b1, "ab_m1_data", ov(2'b10, 1'b1, 1'b0, 1'b0));
        step(2'b10, 2'b10, 1'b1, "ab_m1_rel", O_OFF);
        step(2'b00, 2'b00, 1'b1, "ab_m1_idle", O_OFF);

        // Reset during DATA of master 0 (pointer now favours master 1 on a tie)
        step(2'b01, 2'b00, 1'b1, "rs_grant", ov(2'b01, 1'b0, 1'b0, 1'b0));
        step(2'b01, 2'b00, 1'b1, "rs_addr0", ov(2'b01, 1'b1, 1'b1, 1'b0));
        step(2'b01, 2'b00, 1'b1, "rs_addr1", ov(2'b01, 1'b1, 1'b1, 1'b0));
        step(2'b01, 2'b00, 1'b1, "rs_wait", ov(2'b01, 1'b1, 1'b0, 1'b0));
        step(2'b01, 2'b00, 1'b1, "rs_data", ov(2'b01, 1'b1, 1'b0, 1'b0));
        rst = 1'b1;
        #1;
        push_exp("rs_async_clear", O_OFF);
        pop_check();
        bus_if.M_REQ = 2'b11;
        @(posedge clk);
        #1;
        push_exp("rs_held", O_OFF);
        pop_check();
        rst = 1'b0;
        txn(2'b11, 2'b01, "rs_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Two-master arbiter and transaction sequencer for the serial shared bus. It grants the bus to one requesting master using round-robin order and drives the bus-phase strobes `B_UTIL` and `A_ADD` that the slave address decoder and slaves consume. It waits for the addressed slave's acknowledge and bounds that wait with a timeout. It sits between the master ports and the bus interconnect, one instance per bus.

## Interface
- `ADDR_WIDTH`, default 2: number of serial address bits per transaction, equal to the number of `A_ADD` cycles.
- `TIMEOUT`, default 15: maximum cycles spent in WAIT_ACK before the transaction is aborted. Legal range is 1 to 255.
- `CLK` in 1: bus clock; all logic is on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `M_REQ` in 2: per-master bus request. The master holds it high until it has seen its own `M_DONE` accepted.
- `M_DONE` in 2: per-master end-of-data strobe. Only the granted master's bit is examined.
- `S_READY` in 1: acknowledge from the addressed slave, level-sensitive.
- `M_GRANT` out 2: one-hot grant, or 0 when no master is granted.
- `B_UTIL` out 1: bus busy; high during ADDR, WAIT_ACK and DATA.
- `A_ADD` out 1: address phase strobe.
- `B_ERR` out 1: one-cycle slave-timeout pulse.

## Operation
- All outputs are registered, Moore-style, and decoded from the state and the registered grant index `g`.
- Reset values: state IDLE, all outputs 0, round-robin pointer `last` = 1 so that master 0 wins the first tie, and all counters 0.
- **IDLE:** all outputs 0.
  - If any `M_REQ` bit is high, go to GRANT.
  - Winner selection: a single requester wins outright. If both request, the winner is the master other than `last`.
  - Set `g` to the winner and `last` to the winner.
- **GRANT (1 cycle):** `M_GRANT[g]`=1, `B_UTIL`=0, `A_ADD`=0. The master uses this cycle to present address bit 0 on the bus.
- **ADDR (exactly `ADDR_WIDTH` cycles):** `M_GRANT[g]`=1, `B_UTIL`=1, `A_ADD`=1.
  - Address bits are sent LSB first, one per cycle.
  - A `$clog2(ADDR_WIDTH+1)`-bit counter counts from 0. Exit to WAIT_ACK when it reaches `ADDR_WIDTH`-1.
- **WAIT_ACK:** `B_UTIL`=1, `A_ADD`=0, grant held.
  - An 8-bit timeout counter is cleared on entry.
  - `S_READY`=1 sends the block to DATA.
  - Otherwise the counter increments. When it reaches `TIMEOUT`-1 without `S_READY`, set the error flag and go to RELEASE.
  - `M_DONE` is ignored in this state.
- **DATA:** `B_UTIL`=1, grant held. `M_DONE[g]`=1 sends the block to RELEASE.
- **RELEASE (1 cycle):** `M_GRANT`=0, `B_UTIL`=0, `A_ADD`=0, `B_ERR` = error flag. The flag is cleared on exit. Next state is IDLE.
- **Request drop:** if `M_REQ[g]` falls in GRANT, ADDR, WAIT_ACK or DATA, go to RELEASE. This is an abort with `B_ERR`=0.
- **Non-granted request:** a request from the other master never preempts. It waits, and is guaranteed service next because of the round-robin order.
- **Simultaneous events:**
  - `S_READY` on the timeout cycle: ready wins, no error.
  - Request drop together with `M_DONE[g]`: normal RELEASE, no error.

## Timing
- A request sampled high in IDLE at edge k gives `M_GRANT` high from edge k+1.
- `A_ADD` is high from edge k+2 through edge k+2+`ADDR_WIDTH`.
- Best case with `S_READY` already high: DATA begins `ADDR_WIDTH`+3 edges after the request is sampled, since WAIT_ACK lasts a minimum of 1 cycle.
- The minimum gap between two grants is 2 cycles (RELEASE then IDLE). Grants of two different masters never overlap, and `M_GRANT` is always 0 during RELEASE.
- Timeout: WAIT_ACK lasts exactly `TIMEOUT` cycles. `B_ERR` is high for exactly 1 cycle, in RELEASE.
- Reset asserted mid-transaction forces all outputs to 0 asynchronously. The block restarts in IDLE with `last`=1.

## Test plan
- **Single master, normal transfer:** `ADDR_WIDTH`=2; `M_REQ`=01; `S_READY`=1; `M_DONE[0]` pulsed 3 cycles into DATA.
  - `M_GRANT`=01 one cycle after the request is sampled, then `A_ADD` high for exactly 2 cycles.
  - `B_UTIL` stays high until RELEASE, and `B_ERR` stays 0.
- **Contention:** `M_REQ`=11 held continuously, each transaction ended by `M_DONE`.
  - Grants alternate 01, 10, 01, 10.
  - Every grant is separated by at least 2 cycles of `M_GRANT`=00.
- **Timeout:** `TIMEOUT`=15, `S_READY` held at 0.
  - WAIT_ACK lasts exactly 15 cycles, `B_ERR` pulses for 1 cycle, then the bus returns to IDLE.
  - A later request from the same master is still granted.
- **Boundary:** `S_READY` rises exactly on the 15th WAIT_ACK cycle. Required response: the block enters DATA and `B_ERR` stays 0.
- **Abort:** `M_REQ[0]` drops during the second ADDR cycle. Required response: next cycle is RELEASE with `B_ERR`=0, and a pending `M_REQ[1]` is granted 2 cycles later.
- **Reset mid-operation:** `RST` pulsed during DATA.
  - All outputs drop to 0 without waiting for a clock edge.
  - After release, with `M_REQ`=11, master 0 is granted first.
